tdl: RTL and testbench
======================

# tdl

Tapped delay line for the transmitter datapath. It shifts a 1-bit serial symbol stream through SPAN+1 registered stages and exposes every stage in parallel as a tap vector. Downstream pulse-shaping / FIR logic uses the vector as its window of the most recent SPAN+1 input symbols.

## Interface
- SPAN, default 16: number of symbol periods covered beyond the newest tap. The tap vector has SPAN+1 bits. Legal range is 1..255.
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
- in  input  1  serial input symbol, sampled every rising edge.
- out  output  SPAN+1  tap vector. out[0] holds the newest sample and out[SPAN] the oldest.

## Operation
- State is SPAN+1 flip-flops, d[0..SPAN], and out[k] = d[k]. Outputs are purely registered, with no combinational path from in to out.
- At a rising edge with reset = 1, all of d clears to 0, so out = 0. Reset has priority over shifting.
- At a rising edge with reset = 0, d[0] <= in and d[k] <= d[k-1] for k = 1..SPAN.
- Values older than SPAN+1 samples fall off the end and are discarded. There is no wrap-around or recirculation.
- There is no enable: the line shifts on every non-reset edge.
- Reset asserted mid-stream clears every tap on that edge. Shifting resumes on the first edge with reset = 0, and zeros are visible in all taps not yet refilled.
- Out-of-range SPAN values (0 or >255) must be rejected at elaboration.

## Timing
- Latency from in to out[k] is k+1 rising edges. A value sampled at edge n appears on out[0] after edge n and on out[SPAN] after edge n+SPAN.
- Fill time after reset is SPAN+1 edges. After that, every tap holds valid input history.
- The reset value of out is all zeros, visible from the edge on which reset is sampled high.
- Throughput is one symbol per clock. Inputs must satisfy setup/hold around the rising edge.

## Structure
- A shared transmitter package holds:
  - the default SPAN constant (16);
  - the tap-vector width helper (SPAN+1), so downstream FIR coefficient arrays use the same width.
- A single sub-module, tdl_stage, is natural. It is one flip-flop with synchronous active-high clear.
- tdl instantiates SPAN+1 copies of tdl_stage in a generate loop, chained d[k-1] -> d[k], with stage 0 fed from in.
- The top level also contains the SPAN range check.

## Test plan
- Reset: hold reset = 1 for 2 edges with in = 1 -> out = 0 after the first edge and stays 0.
- Single impulse (SPAN = 16): after reset, in = 1 for one edge, then 0 -> out = 17'h00001, then 17'h00002, doubling each edge. After 17 edges out = 0.
- Alternating input (in toggles every edge, first sample 0) -> once filled, out alternates between 17'h0AAAA and 17'h15555 every edge.
- All ones: hold in = 1 from reset release -> out gains one 1 per edge from bit 0 upward and reaches 17'h1FFFF exactly 17 edges after release.
- Mid-stream reset: run alternating input for 40 edges, then pulse reset for one edge -> out = 0 on that edge, and refilling restarts from bit 0.
- Parameter sweep: SPAN = 1 with an impulse -> out = 2'b01, then 2'b10, then 2'b00.

Source files
------------

// File: rtl/tdl_pkg.sv
// Shared transmitter constants for the tapped delay line and the FIR logic
// that consumes its tap vector.
package tdl_pkg;

    // Default number of symbol periods covered beyond the newest tap.
    localparam int TDL_SPAN_DEFAULT = 16;

    // Legal SPAN range; the top level refuses to elaborate outside it.
    localparam int TDL_SPAN_MIN = 1;
    localparam int TDL_SPAN_MAX = 255;

    // Tap-vector width for a given span. FIR coefficient arrays size
    // themselves with this so they always line up with the tap vector.
    function automatic int tdl_tap_width(input int span);
        return span + 1;
    endfunction

    // True when a span value can be built.
    function automatic bit tdl_span_legal(input int span);
        return (span >= TDL_SPAN_MIN) && (span <= TDL_SPAN_MAX);
    endfunction

endpackage : tdl_pkg

// File: rtl/tdl_stage.sv
// One delay-line stage: a single flip-flop with synchronous active-high clear.
module tdl_stage (
    input  logic clk_i,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    // Clear wins over loading the upstream sample.
    always_comb begin
        q_d = d_i;
        if (clr_i) begin
            q_d = 1'b0;
        end
    end

    // Stage register, updated every rising edge.
    always_ff @(posedge clk_i) begin
        q_q <= q_d;
    end

    assign q_o = q_q;

endmodule : tdl_stage

// File: rtl/tdl.sv
// Tapped delay line: shifts the serial symbol stream through SPAN+1 stages
// and exposes every stage as a tap vector (out[0] newest, out[SPAN] oldest).
module tdl
    import tdl_pkg::*;
#(
    parameter int SPAN = TDL_SPAN_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in,
    output logic [SPAN:0] out
);

    localparam int TAP_W = tdl_tap_width(SPAN);

    // Refuse to build a line with no history or a span beyond the FIR range.
    generate
        if (!tdl_span_legal(SPAN)) begin : g_span_check
            $error("tdl: SPAN=%0d outside legal range %0d..%0d",
                   SPAN, TDL_SPAN_MIN, TDL_SPAN_MAX);
        end
    endgenerate

    logic [TAP_W-1:0] tap_q;

    // Stage 0 samples the serial input; every later stage samples its
    // predecessor, so a symbol reaches tap k after k+1 edges.
    generate
        for (genvar k = 0; k < TAP_W; k++) begin : g_stage
            if (k == 0) begin : g_head
                tdl_stage u_stage (
                    .clk_i (clock),
                    .clr_i (reset),
                    .d_i   (in),
                    .q_o   (tap_q[k])
                );
            end else begin : g_body
                tdl_stage u_stage (
                    .clk_i (clock),
                    .clr_i (reset),
                    .d_i   (tap_q[k-1]),
                    .q_o   (tap_q[k])
                );
            end
        end
    endgenerate

    // Taps leave straight from the stage registers; no path from in to out.
    assign out = tap_q;

endmodule : tdl

// File: tb/tb_tdl.sv
module tb_tdl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        din   = 1'b1;
    logic [16:0] out17;
    logic [1:0]  out2;

    always #5 clock = ~clock;

    tdl #(.SPAN(16)) u_dut16 (
        .clock (clock),
        .reset (reset),
        .in    (din),
        .out   (out17)
    );

    tdl #(.SPAN(1)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .in    (din),
        .out   (out2)
    );

    typedef struct {
        logic [16:0] e17;
        logic [1:0]  e2;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t push_e;
    int   checks = 0;
    int   errors = 0;

    // Drive one edge's inputs and queue what both lines must show after it.
    task automatic step(input logic i, input logic r,
                        input logic [16:0] e17, input logic [1:0] e2,
                        input string tag);
        @(negedge clock);
        din   = i;
        reset = r;
        push_e.e17 = e17;
        push_e.e2  = e2;
        push_e.tag = tag;
        sb.push_back(push_e);
    endtask

    // Alternating stream starting with 0: after edge t, tap j holds sample t-j.
    function automatic logic [16:0] alt17(input int t);
        logic [16:0] p;
        p = (t % 2 == 0) ? 17'h0AAAA : 17'h15555;
        if (t < 16) p = p & ((17'h1 << (t + 1)) - 17'h1);
        return p;
    endfunction

    function automatic logic [1:0] alt2(input int t);
        logic [1:0] p;
        p = (t % 2 == 0) ? 2'b10 : 2'b01;
        if (t < 1) p = p & 2'b01;
        return p;
    endfunction

    function automatic logic [16:0] ones17(input int i);
        if (i >= 16) return 17'h1FFFF;
        return (17'h1 << (i + 1)) - 17'h1;
    endfunction

    function automatic logic [1:0] ones2(input int i);
        return (i >= 1) ? 2'b11 : 2'b01;
    endfunction

    // Monitor: taps are valid every cycle, so pop one expectation per edge.
    always @(posedge clock) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (out17 !== mon_e.e17) begin
                errors++;
                $display("FAIL %s span16: got %h expected %h", mon_e.tag, out17, mon_e.e17);
            end
            checks++;
            if (out2 !== mon_e.e2) begin
                errors++;
                $display("FAIL %s span1: got %b expected %b", mon_e.tag, out2, mon_e.e2);
            end
        end
    end

    initial begin
        int drain;

        // Reset held for two edges with in = 1.
        step(1'b1, 1'b1, 17'h0, 2'b00, "reset_edge1");
        step(1'b1, 1'b1, 17'h0, 2'b00, "reset_edge2");

        // Single impulse.
        step(1'b1, 1'b0, 17'h00001, 2'b01, "impulse_0");
        for (int i = 1; i <= 18; i++) begin
            step(1'b0, 1'b0, (i < 17) ? (17'h1 << i) : 17'h0,
                 (i == 1) ? 2'b10 : 2'b00, $sformatf("impulse_%0d", i));
        end

        // All ones from reset release.
        step(1'b0, 1'b1, 17'h0, 2'b00, "ones_reset");
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, ones17(i), ones2(i), $sformatf("ones_%0d", i));
        end

        // Alternating for 40 edges, mid-stream reset, then refill.
        step(1'b0, 1'b1, 17'h0, 2'b00, "alt_reset");
        for (int t = 0; t < 40; t++) begin
            step(logic'(t % 2), 1'b0, alt17(t), alt2(t), $sformatf("alt_%0d", t));
        end
        step(1'b1, 1'b1, 17'h0, 2'b00, "midstream_reset");
        for (int t = 0; t < 20; t++) begin
            step(logic'(t % 2), 1'b0, alt17(t), alt2(t), $sformatf("refill_%0d", t));
        end

        // Reset while saturated with ones clears every tap at once.
        step(1'b1, 1'b1, 17'h0, 2'b00, "ones_midreset");
        step(1'b1, 1'b0, 17'h00001, 2'b01, "after_midreset");

        drain = 0;
        while (sb.size() != 0 && drain < 10) begin
            @(posedge clock);
            drain++;
        end
        #2;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_tdl
